mult_arbiter: RTL
=================

Name: mult_arbiter

Overview:
Round-robin arbiter that shares one fixed-point multiplier (Q10.21, 32-bit, combinational `a_i`/`b_i` -> `mult_o`) between NumReq requesters, e.g. the x·y, x·z and β·z product terms of the Lorenz integrator.
- Grants at most one requester per cycle.
- Registers the winner's operands toward the external multiplier.
- Captures the product and returns it tagged with a one-hot valid to the originating requester.
- Fully pipelined: one grant per cycle, fixed latency 2.

Parameters:
- Width, 32, operand/result width in bits (two's complement fixed point).
- NumReq, 3, number of requesters (2..8).

Ports:
- `clk_i`  in  1  system clock, rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  NumReq  request level per requester; operands valid while high.
- `a_i`  in  NumReq*Width  flattened operand A; requester k at bits [k*Width +: Width].
- `b_i`  in  NumReq*Width  flattened operand B, same packing.
- `gnt_o`  out  NumReq  one-hot combinational grant; operands of the granted requester are sampled at this clock edge.
- `mult_a_o`  out  Width  registered operand A to the shared multiplier.
- `mult_b_o`  out  Width  registered operand B to the shared multiplier.
- `mult_i`  in  Width  product from the shared multiplier (combinational from `mult_a_o`/`mult_b_o`).
- `result_o`  out  Width  registered product.
- `valid_o`  out  NumReq  one-hot, one-cycle pulse: `result_o` belongs to requester k.
- `busy_o`  out  1  high while any operation is in stage 1 or stage 2.

Behaviour:
- Reset (`rst_ni`=0, async): `mult_a_o`, `mult_b_o`, `result_o` = 0; `valid_o` = 0; `busy_o` = 0; stage-1 valid and ID = 0; last-grant pointer = NumReq-1, so requester 0 has top priority after reset.
- Reset asserted mid-operation: in-flight operations are discarded and no `valid_o` is produced for them. Requesters must re-request.
- Arbitration (combinational, cycle t):
  - Search `req_i` starting at index (last+1) mod NumReq, wrapping.
  - The first set bit wins and `gnt_o` is that one-hot.
  - `gnt_o` = 0 when `req_i` = 0.
- Stage 1 (edge ending cycle t, when a grant exists):
  - `mult_a_o`/`mult_b_o` <= operands of the winner k.
  - s1_valid <= 1, s1_id <= k, last <= k.
  - No grant: s1_valid <= 0, and operand registers hold their value (no toggling).
- Stage 2 (edge ending cycle t+1):
  - `result_o` <= `mult_i`.
  - `valid_o` <= onehot(s1_id) if s1_valid, else 0.
  - `result_o` holds its value when not updated.
- Latency: request granted in cycle t -> `valid_o[k]` high in cycle t+2, for exactly one cycle.
- Throughput: back-to-back grants every cycle. A requester that keeps `req_i` high is re-granted only after every other active requester has been served (strict round-robin, no starvation).
- Requester protocol:
  - On seeing `gnt_o[k]`, the requester either presents new operands next cycle or drops `req_i`.
  - Holding `req_i` with the same operands issues a duplicate operation.
  - The block never stalls (no backpressure on `valid_o`).
- Simultaneous events: a grant to k in cycle t coexists with `valid_o[k]` from an earlier grant. The pipeline stages are independent.
- `busy_o` = s1_valid OR (`valid_o` != 0).
- Arithmetic: the block does not modify data. Width truncation and Q-format scaling are the multiplier's job; `result_o` is `mult_i` bit-exact.
- Pointer wrap: after a grant to NumReq-1, the search starts at index 0.

Test Plan:
1. Reset, then `req_i`=001, `a0`=0x00200000 (1.0), `b0`=0x00200000 -> `gnt_o`=001 in cycle 0; `mult_a_o`=0x00200000 in cycle 1; `valid_o`=001 and `result_o`=0x00200000 in cycle 2; `busy_o` low in cycle 3.
2. All three requesters held high with operands 1.5×1.5, 1.5×(-0.5) (0xFFF00000), 1.0×1.0 -> grants cycle through 001, 010, 100, 001, …. `result_o` sequence is 0x00480000 (2.25), 0xFFE80000 (-0.75), 0x00200000, with matching `valid_o` one-hot pulses two cycles after each grant.
3. After a grant to requester 1, assert `req_i`=011 -> requester 0 is granted before requester 1 is re-granted (pointer wraps past 2).
4. Assert `req_i`=100, then pull `rst_ni` low one cycle after the grant -> all outputs 0 immediately; no `valid_o` pulse after reset release; the next grant goes to requester 0 if requested.
5. Idle gap: one request, then 5 cycles with `req_i`=0 -> `gnt_o`=0, `valid_o`=0; `mult_a_o`/`mult_b_o`/`result_o` hold their last values; `busy_o`=0.

Source files
------------

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one combinational fixed-point multiplier
// between NumReq requesters, with a fixed two-cycle grant-to-result latency.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   req_i [NumReq]       request level per requester; operands valid while high
//   a_i, b_i             flattened operands, requester k at [k*Width +: Width]
//   gnt_o [NumReq]       combinational one-hot grant; winner sampled at this edge
//   mult_a_o, mult_b_o   registered operands toward the shared multiplier
//   mult_i               product returned by the multiplier (combinational)
//   result_o             registered product
//   valid_o [NumReq]     one-cycle one-hot pulse identifying the owner of result_o
//   busy_o               an operation occupies stage 1 or stage 2
module mult_arbiter #(
  parameter int Width  = 32,
  parameter int NumReq = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq*Width-1:0] a_i,
  input  logic [NumReq*Width-1:0] b_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [Width-1:0]        mult_a_o,
  output logic [Width-1:0]        mult_b_o,
  input  logic [Width-1:0]        mult_i,
  output logic [Width-1:0]        result_o,
  output logic [NumReq-1:0]       valid_o,
  output logic                    busy_o
);

  localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [IdW-1:0]    last_q, last_d;
  logic [IdW-1:0]    win_id;
  logic              win_found;
  logic [NumReq-1:0] gnt;

  logic [Width-1:0]  mult_a_q, mult_a_d;
  logic [Width-1:0]  mult_b_q, mult_b_d;
  logic              s1_valid_q, s1_valid_d;
  logic [IdW-1:0]    s1_id_q, s1_id_d;

  logic [Width-1:0]  result_q, result_d;
  logic [NumReq-1:0] valid_q, valid_d;

  // Search starts just past the last winner and wraps, so a requester holding
  // its request is re-served only after every other active requester.
  always_comb begin
    gnt       = '0;
    win_id    = '0;
    win_found = 1'b0;
    for (int i = 1; i <= NumReq; i++) begin
      if (!win_found && req_i[(int'(last_q) + i) % NumReq]) begin
        win_found = 1'b1;
        win_id    = IdW'((int'(last_q) + i) % NumReq);
        gnt[(int'(last_q) + i) % NumReq] = 1'b1;
      end
    end
  end

  // Stage 1: capture the winner's operands. Without a grant the operand
  // registers keep their value so the multiplier inputs do not toggle.
  always_comb begin
    mult_a_d   = mult_a_q;
    mult_b_d   = mult_b_q;
    s1_valid_d = win_found;
    s1_id_d    = s1_id_q;
    last_d     = last_q;
    if (win_found) begin
      mult_a_d = a_i[int'(win_id)*Width +: Width];
      mult_b_d = b_i[int'(win_id)*Width +: Width];
      s1_id_d  = win_id;
      last_d   = win_id;
    end
  end

  // Stage 2: capture the product and tag it with the originating requester.
  always_comb begin
    result_d = result_q;
    valid_d  = '0;
    if (s1_valid_q) begin
      result_d = mult_i;
      valid_d  = NumReq'(1) << s1_id_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= IdW'(NumReq - 1);
      mult_a_q   <= '0;
      mult_b_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      result_q   <= '0;
      valid_q    <= '0;
    end else begin
      last_q     <= last_d;
      mult_a_q   <= mult_a_d;
      mult_b_q   <= mult_b_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
    end
  end

  assign gnt_o    = gnt;
  assign mult_a_o = mult_a_q;
  assign mult_b_o = mult_b_q;
  assign result_o = result_q;
  assign valid_o  = valid_q;
  assign busy_o   = s1_valid_q | (|valid_q);

endmodule
